// File: rtl/acc16_pkg.sv
// Shared constants and FSM state type for the acc16 streaming accumulator.
package acc16_pkg;

    localparam int ACC_W = 16;
    localparam logic [ACC_W-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [ACC_W-1:0] SAT_MIN = 16'h8000;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/acc16_add.sv
// Combinational 16-bit signed adder (carry-in 0) with two's-complement overflow flag.
module acc16_add
    import acc16_pkg::*;
(
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    assign sum = a + b;
    // Overflow only when both operands share a sign that the result does not.
    assign ovf = (a[ACC_W-1] == b[ACC_W-1]) && (sum[ACC_W-1] != a[ACC_W-1]);

endmodule

// File: rtl/acc16_stream.sv
// Streaming accumulator: sums NUM_TERMS signed operands per result, holds it until taken.
// Define ACC16_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module acc16_stream
    import acc16_pkg::*;
#(
    parameter int NUM_TERMS = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACC_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf
);

    localparam int CW = $clog2(NUM_TERMS);
    localparam logic [CW-1:0] LAST = CW'(NUM_TERMS - 1);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic [ACC_W-1:0] acc_nxt;

    acc16_add u_add (
        .a   (acc_q),
        .b   (in_data),
        .sum (add_sum),
        .ovf (add_ovf)
    );

`ifdef ACC16_SAT_EN
    // On overflow both operands share acc_q's sign, so it picks the rail.
    assign acc_nxt = add_ovf ? (acc_q[ACC_W-1] ? SAT_MIN : SAT_MAX) : add_sum;
`else
    assign acc_nxt = add_sum;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    acc_d = acc_nxt;
                    ovf_d = ovf_q | add_ovf;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ACCUM;
        endcase
        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_acc16_stream.sv
// Directed, table-driven bench for acc16_stream (NUM_TERMS 9, plus 2 and 256 instances).
module tb_acc16_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_ovf;
    logic [15:0] in_data, out_data;

    logic        in_valid_b;
    logic        in_ready_2, out_valid_2, out_ovf_2;
    logic        in_ready_256, out_valid_256, out_ovf_256;
    logic [15:0] out_data_2, out_data_256;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    acc16_stream dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
    );

    acc16_stream #(.NUM_TERMS(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_2), .in_data(16'h0001),
        .out_valid(out_valid_2), .out_ready(1'b1), .out_data(out_data_2), .out_ovf(out_ovf_2)
    );

    acc16_stream #(.NUM_TERMS(256)) dut256 (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_256), .in_data(16'h0001),
        .out_valid(out_valid_256), .out_ready(1'b1), .out_data(out_data_256), .out_ovf(out_ovf_256)
    );

    typedef struct {
        string           name;
        logic [8:0][15:0] ops;
        int              max_gap;
        logic [15:0]     exp_data;
        logic            exp_ovf;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [15:0] d, input int max_gap);
        int  g;
        bit  acc;
        g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        repeat (g) begin
            in_valid = 1'b0;
            in_data  = 16'($urandom);
            cycle();
        end
        in_valid = 1'b1;
        in_data  = d;
        acc = 1'b0;
        for (int t = 0; t < 20 && !acc; t++) begin
            acc = in_ready;
            cycle();
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 32'(acc), 32'd1);
    endtask

    task automatic send_n(input logic [15:0] d, input int n);
        for (int i = 0; i < n; i++) send(d, 0);
    endtask

    // Called at the negedge right after the last accept, with out_ready=1.
    task automatic finish_window(input string name, input logic [15:0] exp_d, input logic exp_o);
        chk({name, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_out_data"}, 32'(out_data), 32'(exp_d));
        chk({name, "_out_ovf"}, 32'(out_ovf), 32'(exp_o));
        chk({name, "_in_ready_hold"}, 32'(in_ready), 32'd0);
        cycle();
        chk({name, "_valid_one_cycle"}, 32'(out_valid), 32'd0);
        chk({name, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int cnt2, cnt256;

        for (int v = 0; v < NV; v++) begin
            vecs[v].max_gap = 0;
            vecs[v].ops     = '0;
        end
        vecs[0].name = "seq1to9";
        for (int i = 0; i < 9; i++) vecs[0].ops[i] = 16'(i + 1);
        vecs[0].exp_data = 16'h002D; vecs[0].exp_ovf = 1'b0;

        vecs[1].name = "pos_ovf";
        vecs[1].ops[0] = 16'h7000; vecs[1].ops[1] = 16'h2000;
`ifdef ACC16_SAT_EN
        vecs[1].exp_data = 16'h7FFF;
`else
        vecs[1].exp_data = 16'h9000;
`endif
        vecs[1].exp_ovf = 1'b1;

        vecs[2].name = "minus1";
        for (int i = 0; i < 9; i++) vecs[2].ops[i] = 16'hFFFF;
        vecs[2].exp_data = 16'hFFF7; vecs[2].exp_ovf = 1'b0;

        vecs[3] = vecs[2];
        vecs[3].name = "minus1_gaps"; vecs[3].max_gap = 3;

        vecs[4].name = "neg_ovf";
        vecs[4].ops[0] = 16'h8000; vecs[4].ops[1] = 16'h8000;
`ifdef ACC16_SAT_EN
        vecs[4].exp_data = 16'h8000;
`else
        vecs[4].exp_data = 16'h0000;
`endif
        vecs[4].exp_ovf = 1'b1;

        vecs[5].name = "ovf_sticky";
        vecs[5].ops[0] = 16'h7000; vecs[5].ops[1] = 16'h2000; vecs[5].ops[2] = 16'h7000;
`ifdef ACC16_SAT_EN
        vecs[5].exp_data = 16'h7FFF;
`else
        vecs[5].exp_data = 16'h0000;
`endif
        vecs[5].exp_ovf = 1'b1;

        vecs[6].name = "twos";
        for (int i = 0; i < 9; i++) vecs[6].ops[i] = 16'h0002;
        vecs[6].exp_data = 16'd18; vecs[6].exp_ovf = 1'b0;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; in_valid_b = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);

        for (int v = 0; v < NV; v++) begin
            for (int i = 0; i < 9; i++) send(vecs[v].ops[i], vecs[v].max_gap);
            finish_window(vecs[v].name, vecs[v].exp_data, vecs[v].exp_ovf);
        end

        // Backpressure: result held, operands offered during HOLD must not be taken.
        out_ready = 1'b0;
        send_n(16'h0003, 9);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_data = 16'h1234;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'd27);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            cycle();
        end
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_acc_clr", 32'(out_data), 32'd0);
        for (int i = 0; i < 9; i++) send(16'(i + 1), 0);
        finish_window("after_hold", 16'h002D, 1'b0);

        // Reset while holding a result discards it.
        out_ready = 1'b0;
        send_n(16'h0001, 9);
        chk("pre_rst_hold", 32'(out_valid), 32'd1);
        rst = 1'b1; out_ready = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_hold_valid", 32'(out_valid), 32'd0);
        chk("rst_hold_data", 32'(out_data), 32'd0);
        chk("rst_hold_in_ready", 32'(in_ready), 32'd1);

        // Reset mid-window: partial sum and term count discarded.
        send_n(16'h0005, 4);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_data", 32'(out_data), 32'd0);
        send_n(16'h0002, 9);
        finish_window("after_rst_mid", 16'd18, 1'b0);

        // NUM_TERMS 2 / 256 instances with a continuous stream of ones.
        cnt2 = 0; cnt256 = 0;
        in_valid_b = 1'b1;
        for (int c = 0; c < 514; c++) begin
            cycle();
            if (out_valid_2) begin
                cnt2++;
                chk("n2_data", 32'(out_data_2), 32'd2);
            end
            if (out_valid_256) begin
                cnt256++;
                chk("n256_data", 32'(out_data_256), 32'd256);
                chk("n256_ovf", 32'(out_ovf_256), 32'd0);
            end
        end
        in_valid_b = 1'b0;
        chk("n2_count", 32'(cnt2), 32'd171);
        chk("n256_count", 32'(cnt256), 32'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/acc16_stream.md
ACC16_STREAM -- requirements
Module: acc16_stream

Interface
REQ-001 Parameter NUM_TERMS, default 9, number of operands summed per result; legal range 2..256.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream operand valid.
REQ-005 in_ready  output  1  block accepts operand this cycle.
REQ-006 in_data  input  16  signed two's-complement operand.
REQ-007 out_valid  output  1  accumulated result valid.
REQ-008 out_ready  input  1  downstream accepts result.
REQ-009 out_data  output  16  signed accumulated result.
REQ-010 out_ovf  output  1  sticky: signed overflow occurred at least once in this window.

Function
REQ-011 Two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-012 Operand accepted when in_valid && in_ready; acc <= acc + in_data (16-bit signed add, carry-in 0).
REQ-013 Term counter counts accepted operands 0..NUM_TERMS-1, width $clog2(NUM_TERMS).
REQ-014 Acceptance at count NUM_TERMS-1: ACCUM->HOLD next cycle, counter -> 0; out_data valid one cycle after last accept.
REQ-015 ACCUM with in_valid=0: acc, counter and out_ovf hold.
REQ-016 HOLD: out_data and out_ovf stable while out_ready=0; no operand accepted.
REQ-017 HOLD with out_ready=1: HOLD->ACCUM next cycle, acc -> 0, out_ovf -> 0.
REQ-018 No first-operand acceptance in the result-handshake cycle; minimum NUM_TERMS+1 cycles per result.
REQ-019 Overflow of one add = operands same sign and raw sum sign differs; sets out_ovf (sticky until window clears).
REQ-020 out_data drives acc register directly; no combinational path from in_* to out_*.
REQ-021 out_ready ignored in ACCUM; in_valid ignored in HOLD.

Reset
REQ-022 rst=1 at clock edge: state ACCUM, acc=0x0000, counter=0, out_ovf=0, out_valid=0, in_ready=1 from the next cycle.
REQ-023 rst mid-window or in HOLD discards partial/pending result; no out_valid pulse generated.
REQ-024 rst has priority over any simultaneous handshake.

Configuration
REQ-025 Macro ACC16_SAT_EN: defined -> on overflow acc saturates to 0x7FFF (positive) or 0x8000 (negative), later adds continue from saturated value.
REQ-026 ACC16_SAT_EN undefined -> acc wraps modulo 2^16; out_ovf behaviour identical in both builds.

Structure
REQ-027 Shared package acc16_pkg holds ACC_W=16, SAT_MAX=16'h7FFF, SAT_MIN=16'h8000, and the state enum (ACCUM, HOLD).
REQ-028 One sub-module, acc16_add: combinational 16-bit adder returning sum and overflow; saturation mux lives in acc16_stream.
REQ-029 Counter, FSM, acc and ovf registers in acc16_stream; target 120-400 lines RTL total.

Verification
REQ-030 NUM_TERMS=9, operands 1..9 back-to-back, out_ready=1 -> out_data=45 (0x002D), out_ovf=0, out_valid one cycle after 9th accept, one cycle long.
REQ-031 Operands 0x7000 then 0x2000, rest 0 -> out_ovf=1; out_data=0x7FFF with ACC16_SAT_EN, 0x9000 without.
REQ-032 Operands -1 (0xFFFF) x9 -> out_data=0xFFF7, out_ovf=0; in_valid gaps of random length give identical result.
REQ-033 Result held with out_ready=0 for 5 cycles -> out_data stable, in_ready=0, in_valid operands not consumed; next window after release sums from 0.
REQ-034 rst asserted after 4 accepted operands -> no result; following 9 operands of 2 -> out_data=18.
REQ-035 NUM_TERMS=2 and 256 builds: operands 0x0001 -> out_data=2 and 256 respectively, counter wraps to 0 each window.
